sample_ctrl: RTL and testbench

SAMPLE_CTRL -- requirements
Module: sample_ctrl

---
 rtl/sample_ctrl.sv | 136 +++++++++++++
 tb/tb_sample_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_ctrl.sv
// Sequencer for the Ising sampler: preload, free-run window, then stream
// one phase word per spin over a valid/ready port.
`ifndef PHASE_ADDR_BASE
`define PHASE_ADDR_BASE 32'h0000_1000
`endif

module sample_ctrl #(
  parameter int          N            = 3,
  parameter logic [31:0] ADDR_BASE    = `PHASE_ADDR_BASE,
  parameter int          CLEAR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] run_cycles,
  output logic        busy,
  output logic        done,
  output logic        sample_rstn,
  output logic        sample_hold,
  output logic        osc_en,
  output logic [31:0] rd_addr,
  input  logic [31:0] phase,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_index,
  output logic        out_last
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_READ, S_DONE} state_t;

  state_t      r_state, w_nstate;
  logic [31:0] r_len, w_nlen;
  logic [31:0] r_cnt, w_ncnt;
  logic [31:0] r_idx, w_nidx;
  logic [3:0]  r_clr, w_nclr;
  logic        w_xfer;

  assign w_xfer   = (r_state == S_READ) && out_valid && out_ready;
  assign out_data = phase;
  assign out_index = r_idx;

  always_comb begin
    w_nstate = r_state;
    w_nlen   = r_len;
    w_ncnt   = r_cnt;
    w_nidx   = r_idx;
    w_nclr   = r_clr;
    case (r_state)
      S_IDLE: if (start) begin
        w_nstate = S_CLEAR;
        w_nlen   = run_cycles;
        w_nclr   = 4'd0;
      end
      S_CLEAR: begin
        if (abort) begin
          w_nstate = S_IDLE;
        end else if (r_clr == 4'(CLEAR_CYCLES - 1)) begin
          if (r_len == 32'd0) begin
            w_nstate = S_READ;
            w_nidx   = 32'd0;
          end else begin
            w_nstate = S_RUN;
            w_ncnt   = r_len;
          end
        end else begin
          w_nclr = r_clr + 4'd1;
        end
      end
      S_RUN: begin
        // <=1 rather than ==1 keeps the counter from ever wrapping below zero
        if (abort) begin
          w_nstate = S_IDLE;
          w_ncnt   = 32'd0;
        end else if (r_cnt <= 32'd1) begin
          w_nstate = S_READ;
          w_ncnt   = 32'd0;
          w_nidx   = 32'd0;
        end else begin
          w_ncnt = r_cnt - 32'd1;
        end
      end
      S_READ: begin
        if (abort) begin
          w_nstate = S_IDLE;
          w_nidx   = 32'd0;
        end else if (w_xfer) begin
          if (r_idx == 32'(N - 1)) begin
            w_nstate = S_DONE;
            w_nidx   = 32'd0;
          end else begin
            w_nidx = r_idx + 32'd1;
          end
        end
      end
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe while still coming straight out of flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= 32'd0;
      r_cnt       <= 32'd0;
      r_idx       <= 32'd0;
      r_clr       <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sample_rstn <= 1'b1;
      sample_hold <= 1'b1;
      osc_en      <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      rd_addr     <= ADDR_BASE;
    end else begin
      r_state     <= w_nstate;
      r_len       <= w_nlen;
      r_cnt       <= w_ncnt;
      r_idx       <= w_nidx;
      r_clr       <= w_nclr;
      busy        <= (w_nstate != S_IDLE);
      done        <= (w_nstate == S_DONE);
      sample_rstn <= (w_nstate != S_CLEAR);
      sample_hold <= (w_nstate != S_CLEAR) && (w_nstate != S_RUN);
      osc_en      <= (w_nstate == S_RUN);
      out_valid   <= (w_nstate == S_READ);
      out_last    <= (w_nstate == S_READ) && (w_nidx == 32'(N - 1));
      rd_addr     <= (w_nstate == S_READ) ? ADDR_BASE + {w_nidx[29:0], 2'b00} : ADDR_BASE;
    end
  end

endmodule

// File: tb/tb_sample_ctrl.sv
// Directed bench for sample_ctrl: basic run, backpressure, zero window,
// abort, reset mid-read and start gating.
module tb_sample_ctrl;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] PMSK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [31:0] run_cycles, phase, rd_addr, out_data, out_index;
  logic        busy, done, sample_rstn, sample_hold, osc_en, out_valid, out_last;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  // sampler model: phase word is a fixed function of the address
  assign phase = rd_addr ^ PMSK;

  sample_ctrl #(.N(3), .ADDR_BASE(BASE), .CLEAR_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .run_cycles(run_cycles),
    .busy(busy), .done(done), .sample_rstn(sample_rstn), .sample_hold(sample_hold),
    .osc_en(osc_en), .rd_addr(rd_addr), .phase(phase), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_vld"},  32'(out_valid), 0);
    chk({tag, "_osc"},  32'(osc_en), 0);
    chk({tag, "_hold"}, 32'(sample_hold), 1);
    chk({tag, "_rstn"}, 32'(sample_rstn), 1);
    chk({tag, "_addr"}, rd_addr, BASE);
    chk({tag, "_idx"},  out_index, 0);
    chk({tag, "_last"}, 32'(out_last), 0);
  endtask

  task automatic beat(input string tag, input int b);
    chk({tag, "_vld"},  32'(out_valid), 1);
    chk({tag, "_idx"},  out_index, 32'(b));
    chk({tag, "_addr"}, rd_addr, BASE + 32'(4 * b));
    chk({tag, "_data"}, out_data, (BASE + 32'(4 * b)) ^ PMSK);
    chk({tag, "_last"}, 32'(out_last), (b == 2) ? 1 : 0);
    chk({tag, "_hold"}, 32'(sample_hold), 1);
    chk({tag, "_osc"},  32'(osc_en), 0);
  endtask

  // Count edges after the start edge until done is seen, bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 60) begin
      tick;
      cnt++;
    end
  endtask

  task automatic do_start(input logic [31:0] rc);
    run_cycles = rc;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; run_cycles = 32'd0;
    tick; tick;
    rst = 1'b0;
    chk_reset_vals("rst");
    tick;

    // basic run: 2 CLEAR, 5 RUN, 3 beats, 1 DONE = 11 busy cycles; counting
    // the start edge as edge 1, busy is low after edge 12
    do_start(32'd5);
    for (int i = 0; i < 2; i++) begin
      chk("clr_rstn", 32'(sample_rstn), 0);
      chk("clr_hold", 32'(sample_hold), 0);
      chk("clr_osc",  32'(osc_en), 0);
      chk("clr_busy", 32'(busy), 1);
      tick;
    end
    for (int i = 0; i < 5; i++) begin
      chk("run_osc",  32'(osc_en), 1);
      chk("run_rstn", 32'(sample_rstn), 1);
      chk("run_hold", 32'(sample_hold), 0);
      chk("run_vld",  32'(out_valid), 0);
      tick;
    end
    for (int b = 0; b < 3; b++) begin
      beat("basic", b);
      tick;
    end
    chk("basic_done", 32'(done), 1);
    chk("basic_dbusy", 32'(busy), 1);
    chk("basic_dvld", 32'(out_valid), 0);
    tick;
    chk("basic_done_off", 32'(done), 0);
    chk("basic_busy_off", 32'(busy), 0);
    tick;

    // backpressure on beat 1
    do_start(32'd1);
    tick; tick; tick;
    beat("bp0", 0);
    tick;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat("bp_hold", 1);
      tick;
    end
    out_ready = 1'b1;
    beat("bp1", 1);
    tick;
    beat("bp2", 2);
    tick;
    chk("bp_done", 32'(done), 1);
    tick; tick;

    // zero window: READ right after the two CLEAR cycles, osc never on
    do_start(32'd0);
    for (int i = 0; i < 2; i++) begin
      chk("zw_clr_osc", 32'(osc_en), 0);
      chk("zw_clr_vld", 32'(out_valid), 0);
      tick;
    end
    for (int b = 0; b < 3; b++) begin
      beat("zw", b);
      tick;
    end
    chk("zw_done", 32'(done), 1);
    chk("zw_done_osc", 32'(osc_en), 0);
    tick; tick;

    // abort in RUN cycle 3
    do_start(32'd5);
    tick; tick; tick; tick;
    chk("ab_in_run", 32'(osc_en), 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_osc", 32'(osc_en), 0);
    for (int i = 0; i < 10; i++) begin
      chk("ab_quiet", 32'({done, out_valid}), 0);
      tick;
    end
    do_start(32'd2);
    wait_done(n);
    chk("ab_rerun_len", 32'(n), 32'd7);
    tick; tick;

    // abort wins over a same-cycle final transfer
    do_start(32'd0);
    tick; tick; tick; tick;
    beat("abl", 2);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abl_done", 32'(done), 0);
    chk("abl_busy", 32'(busy), 0);
    tick;

    // reset at idx=1 wins over abort and start
    do_start(32'd1);
    tick; tick; tick; tick;
    beat("rr", 1);
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    tick;
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    chk_reset_vals("rmid");
    tick;

    // start while busy ignored; latched window stays at 4
    do_start(32'd4);
    run_cycles = 32'd9;
    start = 1'b1;
    tick; tick;
    start = 1'b0;
    n = 2;
    while (!done && n < 60) begin
      tick;
      n++;
    end
    chk("sg_len", 32'(n), 32'd9);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("sg_done_start", 32'(busy), 0);
    tick;
    chk("sg_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
